bcd_disp_ctrl: RTL and testbench
================================

BCD_DISP_CTRL -- requirements
Module: bcd_disp_ctrl

Interface
REQ-001 Parameter: HOLD_CYC, default 4, minimum cycles a new display value is held before the next request is accepted (0..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_a  input  1  requester A wants val_a displayed; held high until gnt_a.
REQ-005 val_a  input  7  unsigned value 0..127 from requester A; stable while req_a is high.
REQ-006 gnt_a  output  1  one-cycle grant; val_a is captured at the rising edge ending this cycle.
REQ-007 req_b / val_b / gnt_b  input/input/output  1/7/1  same meaning as REQ-004..006 for requester B.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 done  output  1  one-cycle pulse: new segment values are visible this cycle.
REQ-010 seg0, seg1, seg2  output  7 each, index [0:6] = segments a..g, active-low  ones, tens and hundreds digit.

Function
REQ-011 FSM states: IDLE, SHIFT, UPDATE, HOLD; all outputs registered, except gnt_a/gnt_b, which are decoded from state plus arbitration.
REQ-012 IDLE with no request: stay in IDLE with both gnt low.
REQ-013 IDLE with a request: grant exactly one requester; capture its value; clear BCD digits; go to SHIFT with bit counter 0.
REQ-014 Arbitration is round-robin: on simultaneous requests, grant the requester not granted last; a lone request is always granted.
REQ-015 A requester that drops req before gnt forfeits the grant; no value is captured from it.
REQ-016 SHIFT lasts exactly 7 cycles (double-dabble, MSB first).
REQ-017 In each SHIFT cycle, add 3 to every BCD digit that is >=5, then shift the left-shifted capture register's MSB into the BCD register.
REQ-018 The ones, tens and hundreds digits are 4 bits each; the hundreds digit never exceeds 1.
REQ-019 UPDATE lasts one cycle: encode the three digits into seg0/seg1/seg2 at its ending edge.
REQ-020 done is high in the cycle immediately after UPDATE.
REQ-021 Latency: segments change 8 rising edges after the grant edge.
REQ-022 After UPDATE, enter HOLD for HOLD_CYC cycles, then IDLE; with HOLD_CYC=0, go directly to IDLE.
REQ-023 Requests arriving during SHIFT, UPDATE or HOLD are not granted until IDLE.
REQ-024 Segment encoding (abcdefg, 0 = lit):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
- blank=1111111
REQ-025 Segment outputs hold their last value through SHIFT, HOLD and IDLE.

Reset
REQ-026 rst_n low forces: FSM to IDLE; gnt_a, gnt_b, busy and done to 0; seg0, seg1, seg2 to digit 0 (0000001); round-robin last-granted to B, so A wins the first tie.
REQ-027 Reset mid-operation aborts the conversion: the captured value is discarded, no done is produced, and outputs take reset values immediately (asynchronously).

Configuration
REQ-028 With LEADING_ZERO_BLANK_EN defined:
- hundreds digit 0 -> seg2 = blank;
- hundreds and tens both 0 -> seg1 = blank;
- seg0 is never blanked;
- reset values become seg2 = seg1 = blank, seg0 = 0000001.
Without the macro, all three digits always display, including leading zeros.

Verification
REQ-029 Reset release -> seg0/seg1/seg2 = 0000001, busy=0, done=0, gnt low.
REQ-030 req_a, val_a=127 -> gnt_a for one cycle; 8 edges later seg2=1001111, seg1=0010010, seg0=0001111; done pulses once.
REQ-031 req_a (val 5) and req_b (val 99) both high from reset -> A granted first (shows 005), then B after HOLD (shows 099); a repeat tie grants A.
REQ-032 rst_n pulsed low during the 4th SHIFT cycle of val 64 -> outputs at reset values immediately; no done; next request converts correctly.
REQ-033 HOLD_CYC=4, req_b held high continuously -> successive gnt_b exactly 4+8+1 = 13 cycles apart (4 HOLD, 7 SHIFT, 1 UPDATE, 1 IDLE); busy never low for more than one cycle.
REQ-034 LEADING_ZERO_BLANK_EN defined:
- val 7 -> seg2 = seg1 = 1111111, seg0 = 0001111;
- val 100 -> seg2 = 1001111, seg1 = seg0 = 0000001.

Source files
------------

// File: rtl/bcd_disp_ctrl.sv
// Arbitrated 7-bit binary to 3-digit BCD seven-segment display controller (double-dabble).
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module bcd_disp_ctrl #(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [6:0] val_a,
    output logic       gnt_a,
    input  logic       req_b,
    input  logic [6:0] val_b,
    output logic       gnt_b,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg0,   // bit 6 = segment a ... bit 0 = segment g, active-low
    output logic [6:0] seg1,
    output logic [6:0] seg2
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [7:0] HOLD_LAST = (HOLD_CYC == 0) ? 8'd0 : 8'(HOLD_CYC - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_RST_HI = SEG_BLANK;
`else
    localparam logic [6:0] SEG_RST_HI = SEG_ZERO;
`endif

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0001100;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [6:0]  r_cap;
    logic [11:0] r_bcd;
    logic        r_last_b;
    logic        r_busy;
    logic        r_done;
    logic [6:0]  r_seg0, r_seg1, r_seg2;

    logic [1:0]  w_next;
    logic        w_pick_a, w_pick_b, w_idle;
    logic [3:0]  w_hund, w_tens, w_ones;
    logic [3:0]  w_tens_adj, w_ones_adj;

    // Round-robin: on a tie, A wins only if B was granted last.
    assign w_pick_a = req_a && (!req_b || r_last_b);
    assign w_pick_b = req_b && !w_pick_a;
    assign w_idle   = rst_n && (r_state == IDLE);
    assign gnt_a    = w_idle && w_pick_a;
    assign gnt_b    = w_idle && w_pick_b;

    assign w_hund     = r_bcd[11:8];
    assign w_tens     = r_bcd[7:4];
    assign w_ones     = r_bcd[3:0];
    assign w_tens_adj = add3(w_tens);
    assign w_ones_adj = add3(w_ones);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (req_a || req_b) w_next = SHIFT;
            SHIFT:  if (r_cnt == 8'd6) w_next = UPDATE;
            UPDATE: w_next = (HOLD_CYC == 0) ? IDLE : HOLD;
            HOLD:   if (r_cnt == HOLD_LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_cap    <= '0;
            r_bcd    <= '0;
            r_last_b <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_seg0   <= SEG_ZERO;
            r_seg1   <= SEG_RST_HI;
            r_seg2   <= SEG_RST_HI;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (r_state == UPDATE);
            case (r_state)
                IDLE: begin
                    if (w_pick_a || w_pick_b) begin
                        r_cap    <= w_pick_a ? val_a : val_b;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_last_b <= w_pick_b;
                    end
                end
                SHIFT: begin
                    // Hundreds never exceeds 1 for a 7-bit input, so its add-3 step is a no-op.
                    r_bcd <= {w_hund[2:0], w_tens_adj, w_ones_adj, r_cap[6]};
                    r_cap <= {r_cap[5:0], 1'b0};
                    r_cnt <= r_cnt + 8'd1;
                end
                UPDATE: begin
                    r_cnt  <= '0;
                    r_seg0 <= seg_enc(w_ones);
`ifdef LEADING_ZERO_BLANK_EN
                    r_seg1 <= (w_hund == 4'd0 && w_tens == 4'd0) ? SEG_BLANK : seg_enc(w_tens);
                    r_seg2 <= (w_hund == 4'd0) ? SEG_BLANK : seg_enc(w_hund);
`else
                    r_seg1 <= seg_enc(w_tens);
                    r_seg2 <= seg_enc(w_hund);
`endif
                end
                HOLD: r_cnt <= r_cnt + 8'd1;
                default: r_cnt <= '0;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign seg0 = r_seg0;
    assign seg1 = r_seg1;
    assign seg2 = r_seg2;

endmodule

// File: tb/tb_bcd_disp_ctrl.sv
// Scoreboard bench for bcd_disp_ctrl: stimulus pushes expected segments/done cycle, a forked monitor checks on done.
module tb_bcd_disp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [6:0] val_a = '0, val_b = '0;
    logic       gnt_a, gnt_b, busy, done;
    logic [6:0] seg0, seg1, seg2;

    bcd_disp_ctrl #(.HOLD_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .val_a(val_a), .gnt_a(gnt_a),
        .req_b(req_b), .val_b(val_b), .gnt_b(gnt_b),
        .busy(busy), .done(done),
        .seg0(seg0), .seg1(seg1), .seg2(seg2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [6:0] D0 = 7'b0000001, D1 = 7'b1001111, D2 = 7'b0010010;
    localparam logic [6:0] D4 = 7'b1001100, D5 = 7'b0100100, D6 = 7'b0100000;
    localparam logic [6:0] D7 = 7'b0001111, D9 = 7'b0001100, BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BL;
`else
    localparam logic [6:0] LZ = D0;
`endif
    localparam logic [20:0] RST_SEGS = {LZ, LZ, D0};

    // Hand-derived displays {seg2,seg1,seg0} for the directed values.
    function automatic logic [20:0] exp_segs(input int v);
        case (v)
            127:     return {D1, D2, D7};
            100:     return {D1, D0, D0};
            99:      return {LZ, D9, D9};
            64:      return {LZ, D6, D4};
            42:      return {LZ, D4, D2};
            7:       return {LZ, LZ, D7};
            5:       return {LZ, LZ, D5};
            default: return '0;
        endcase
    endfunction

    typedef struct {
        logic [20:0] segs;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0, n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("segs", 32'({seg2, seg1, seg0}), 32'(e.segs));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic wait_gnt(input bit exp_b, input int v);
        bit got = 0;
        bit gb;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin got = 1; break; end
        end
        if (!got) begin
            chk("gnt_timeout", 32'(gnt_a | gnt_b), 32'd1);
            return;
        end
        gb = gnt_b;
        chk("gnt_sel", 32'(gnt_b), 32'(exp_b));
        chk("gnt_onehot", 32'(gnt_a & gnt_b), 32'd0);
        sb.push_back('{exp_segs(v), cyc + 9});
        @(posedge clk); #1;
        if (gb) req_b = 1'b0; else req_a = 1'b0;
        @(negedge clk);
        chk("gnt_one_cycle", 32'(gnt_a | gnt_b), 32'd0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int prev;
        int lowrun;
        int maxlow;
        bit got;
        fork monitor(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_segs", 32'({seg2, seg1, seg0}), 32'(RST_SEGS));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);

        // Lone request, max value
        @(posedge clk); #1 val_a = 7'd127; req_a = 1'b1;
        wait_gnt(1'b0, 127);
        wait_idle();

        // Tie from reset: A first, then B; repeat tie goes to A again
        rst_n = 1'b0; req_a = 1'b1; val_a = 7'd5; req_b = 1'b1; val_b = 7'd99;
        #1;
        chk("rst_gnt_a_held", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b_held", 32'(gnt_b), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_gnt(1'b0, 5);
        wait_gnt(1'b1, 99);
        wait_idle();
        @(posedge clk); #1 req_a = 1'b1; val_a = 7'd7; req_b = 1'b1; val_b = 7'd42;
        wait_gnt(1'b0, 7);
        wait_gnt(1'b1, 42);
        wait_idle();

        // Reset in the 4th SHIFT cycle aborts the conversion
        @(posedge clk); #1 req_a = 1'b1; val_a = 7'd64;
        wait_gnt(1'b0, 64);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_segs", 32'({seg2, seg1, seg0}), 32'(RST_SEGS));
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge clk); #1 rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_abort", 32'(nd), 32'd0);
        chk("abort_segs_held", 32'({seg2, seg1, seg0}), 32'(RST_SEGS));
        @(posedge clk); #1 req_a = 1'b1; val_a = 7'd64;
        wait_gnt(1'b0, 64);
        wait_idle();

        // Continuous B requests: grant spacing and busy gaps
        @(posedge clk); #1 req_b = 1'b1; val_b = 7'd100;
        prev = 0; lowrun = 0; maxlow = 0;
        for (int g = 0; g < 3; g++) begin
            got = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (g > 0) begin
                    lowrun = busy ? 0 : lowrun + 1;
                    if (lowrun > maxlow) maxlow = lowrun;
                end
                if (gnt_b) begin got = 1; break; end
            end
            if (!got) begin
                chk("gnt_b_timeout", 32'(gnt_b), 32'd1);
                break;
            end
            sb.push_back('{exp_segs(100), cyc + 9});
            if (g > 0) chk("gnt_b_spacing", 32'(cyc - prev), 32'd13);
            prev = cyc;
            @(posedge clk); #1;
            if (g == 2) req_b = 1'b0;
        end
        chk("busy_low_max", 32'(maxlow), 32'd1);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
